// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: demand-driven NS/EW/pedestrian signal phase controller
module intersection_phase_scheduler #(
  parameter int MIN_G  = 4,
  parameter int MAX_G  = 10,
  parameter int Y_T    = 2,
  parameter int AR_T   = 1,
  parameter int WALK_T = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_btn,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    S_ALL_R    = 3'd0,
    S_NS_G     = 3'd1,
    S_NS_Y     = 3'd2,
    S_EW_G     = 3'd3,
    S_EW_Y     = 3'd4,
    S_WALK     = 3'd5,
    S_WALK_CLR = 3'd6
  } state_t;
  localparam logic [8:0] MIN_N    = 9'(MIN_G);
  localparam logic [8:0] MAX_N    = 9'(MAX_G);
  localparam logic [7:0] Y_END    = 8'(Y_T - 1);
  localparam logic [7:0] AR_END   = 8'(AR_T - 1);
  localparam logic [7:0] WALK_END = 8'(WALK_T - 1);
  state_t     state_q, state_d, pick;
  logic [7:0] cnt_q, cnt_d, n_sat;
  logic [8:0] n;
  logic       last_ns_q, last_ns_d, ped_pend_q, ped_pend_d;
  logic       opp_req, last_req, own, conf, is_ns;
  // State, timer, last-served direction and pedestrian latch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_ALL_R;
      cnt_q      <= 8'd0;
      last_ns_q  <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ns_q  <= last_ns_d;
      ped_pend_q <= ped_pend_d;
    end
  end
  // Next-state: green arbitration, timed phases and clearance-time direction choice
  always_comb begin
    n          = {1'b0, cnt_q} + 9'd1;
    n_sat      = n[8] ? 8'hff : n[7:0];
    opp_req    = last_ns_q ? ew_req : ns_req;
    last_req   = last_ns_q ? ns_req : ew_req;
    pick       = (!opp_req && last_req) ? (last_ns_q ? S_NS_G : S_EW_G)
                                        : (last_ns_q ? S_EW_G : S_NS_G);
    is_ns      = state_q == S_NS_G;
    own        = is_ns ? ns_req : ew_req;
    conf       = (is_ns ? ew_req : ns_req) | ped_pend_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ns_d  = last_ns_q;
    case (state_q)
      S_ALL_R, S_WALK_CLR: if (tick) begin
        if (cnt_q == AR_END) begin
          state_d = (state_q == S_ALL_R && (ped_pend_q || ped_btn)) ? S_WALK : pick;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_NS_G, S_EW_G: if (tick) begin
        if (n >= MIN_N && conf && (!own || n >= MAX_N)) begin
          state_d = is_ns ? S_NS_Y : S_EW_Y;
          cnt_d   = 8'd0;
        end else cnt_d = n_sat;
      end
      S_NS_Y, S_EW_Y: if (tick) begin
        if (cnt_q == Y_END) begin
          state_d   = S_ALL_R;
          cnt_d     = 8'd0;
          last_ns_d = state_q == S_NS_Y;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_WALK: if (tick) begin
        if (cnt_q == WALK_END) begin
          state_d = S_WALK_CLR;
          cnt_d   = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: begin
        state_d = S_ALL_R;
        cnt_d   = 8'd0;
      end
    endcase
    ped_pend_d = (state_d == S_WALK) ? 1'b0 : (ped_pend_q | (ped_btn && state_q != S_WALK));
  end
  assign ns_g     = state_q == S_NS_G;
  assign ns_y     = state_q == S_NS_Y;
  assign ns_r     = !(ns_g || ns_y);
  assign ew_g     = state_q == S_EW_G;
  assign ew_y     = state_q == S_EW_Y;
  assign ew_r     = !(ew_g || ew_y);
  assign walk     = state_q == S_WALK;
  assign ped_pend = ped_pend_q;
  assign phase    = state_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed scenario bench for the phase scheduler
module tb_intersection_phase_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, tick, ns_req, ew_req, ped_btn;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend;
  logic [2:0] phase;
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  int         n;

  intersection_phase_scheduler #(.MIN_G(4), .MAX_G(10), .Y_T(2), .AR_T(1), .WALK_T(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ns_req(ns_req), .ew_req(ew_req), .ped_btn(ped_btn),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .walk(walk), .ped_pend(ped_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    if (mon_en && (!$onehot({ns_g, ns_y, ns_r}) || !$onehot({ew_g, ew_y, ew_r}) ||
                   (!ns_r && !ew_r) || (walk && !(ns_r && ew_r)))) begin
      errors++;
      $display("FAIL invariant lamps ns=%b%b%b ew=%b%b%b walk=%b phase=%0d required safe one-hot lamps",
               ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase);
    end
  endtask

  task automatic do_tick();
    repeat (3) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_btn = 1'b1;
    step();
    ped_btn = 1'b0;
  endtask

  task automatic count_ticks(input logic [2:0] p, output int cnt);
    cnt = 0;
    while (phase === p && cnt < 300) begin
      do_tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_btn = 1'b0;
    repeat (2) step();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend} !== 8'b00100100) begin
      errors++; $display("FAIL reset_lamps got %b exp 00100100", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend});
    end
    mon_en = 1'b1;
    rst_n = 1'b1;
    step();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL allr_before_tick got %0d exp 0", phase); end
    do_tick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL first_green got %0d exp 1", phase); end
    repeat (20) do_tick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL ns_rest got %0d exp 1", phase); end
  endtask

  task automatic test_min_green();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    do_tick();
    ew_req = 1'b1;
    count_ticks(3'd1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL min_green_ticks got %0d exp 4", n); end
    count_ticks(3'd2, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL ns_yellow_ticks got %0d exp 2", n); end
    count_ticks(3'd0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL allr_ticks got %0d exp 1", n); end
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL to_ew_green got %0d exp 3", phase); end
  endtask

  task automatic test_max_out();
    ns_req = 1'b1;
    count_ticks(3'd3, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL ew_max_ticks got %0d exp 10", n); end
    count_ticks(3'd4, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL ew_yellow_ticks got %0d exp 2", n); end
    count_ticks(3'd0, n);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL alt_to_ns got %0d exp 1", phase); end
    count_ticks(3'd1, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL ns_max_ticks got %0d exp 10", n); end
    count_ticks(3'd2, n);
    count_ticks(3'd0, n);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL alt_to_ew got %0d exp 3", phase); end
    count_ticks(3'd3, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL ew_max2_ticks got %0d exp 10", n); end
    ns_req = 1'b0;
    count_ticks(3'd4, n);
    count_ticks(3'd0, n);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL same_dir_return got %0d exp 3", phase); end
    ew_req = 1'b0;
  endtask

  task automatic test_ped();
    pulse_ped();
    checks++; if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_latch got %b exp 1", ped_pend); end
    count_ticks(3'd3, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ped_ew_min got %0d exp 4", n); end
    count_ticks(3'd4, n);
    count_ticks(3'd0, n);
    checks++; if ({phase, walk, ped_pend} !== 5'b10110) begin
      errors++; $display("FAIL walk_entry got phase=%0d walk=%b pend=%b exp 5 1 0", phase, walk, ped_pend);
    end
    do_tick();
    pulse_ped();
    checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL ped_in_walk got %b exp 0", ped_pend); end
    do_tick();
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL walk_len got %0d exp 5", phase); end
    do_tick();
    checks++; if (phase !== 3'd6) begin errors++; $display("FAIL walk_clr got %0d exp 6", phase); end
    pulse_ped();
    checks++; if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_in_clr got %b exp 1", ped_pend); end
    do_tick();
    checks++; if ({phase, ped_pend} !== 4'b0011) begin
      errors++; $display("FAIL clr_to_ns got phase=%0d pend=%b exp 1 1", phase, ped_pend);
    end
    count_ticks(3'd1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ped_ns_min got %0d exp 4", n); end
    count_ticks(3'd2, n);
    count_ticks(3'd0, n);
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL second_walk got %0d exp 5", phase); end
    count_ticks(3'd5, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL walk_ticks got %0d exp 3", n); end
    count_ticks(3'd6, n);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL clr_to_ew got %0d exp 3", phase); end
  endtask

  task automatic test_simultaneous();
    ns_req = 1'b1;
    count_ticks(3'd3, n);
    count_ticks(3'd4, n);
    repeat (3) step();
    tick = 1'b1;
    ped_btn = 1'b1;
    step();
    tick = 1'b0;
    ped_btn = 1'b0;
    checks++; if ({phase, ped_pend} !== 4'b1010) begin
      errors++; $display("FAIL tick_and_press got phase=%0d pend=%b exp 5 0", phase, ped_pend);
    end
    count_ticks(3'd5, n);
    count_ticks(3'd6, n);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL post_walk_ns got %0d exp 1", phase); end
  endtask

  task automatic test_freeze();
    ns_req = 1'b0;
    ew_req = 1'b1;
    count_ticks(3'd1, n);
    do_tick();
    repeat (50) step();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL freeze_hold got %0d exp 2", phase); end
    do_tick();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL freeze_resume got %0d exp 0", phase); end
    do_tick();
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL freeze_to_ew got %0d exp 3", phase); end
  endtask

  task automatic test_reset_mid();
    pulse_ped();
    checks++; if (ped_pend !== 1'b1) begin errors++; $display("FAIL mid_ped_latch got %b exp 1", ped_pend); end
    rst_n = 1'b0;
    tick = 1'b1;
    step();
    checks++; if ({phase, ns_r, ew_r, ew_g, ped_pend} !== 7'b0001100) begin
      errors++; $display("FAIL mid_reset got phase=%0d ns_r=%b ew_r=%b ew_g=%b pend=%b exp 0 1 1 0 0",
                        phase, ns_r, ew_r, ew_g, ped_pend);
    end
    rst_n = 1'b1;
    tick = 1'b0;
    do_tick();
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL reset_last_dir got %0d exp 3", phase); end
  endtask

  initial begin
    test_reset();
    test_min_green();
    test_max_out();
    test_ped();
    test_simultaneous();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
